// File: rtl/rv32i_pkg.sv
// Shared constants and types for the register-file write arbiter.
//   XLEN / NREG / AW : register width, register count, register address width
//   arb_state_e      : arbiter FSM states (ARB, LOCK)
//   REQ_*            : requester indices into the grant vector
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = $clog2(NREG);

    localparam int unsigned NREQ    = 3;
    localparam int unsigned REQ_WB  = 0;
    localparam int unsigned REQ_ID  = 1;
    localparam int unsigned REQ_DBG = 2;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rv32i_rf_wr_stage.sv
// Output register of the RF write port plus forwarding compare for the two
// ID-stage read ports.
//   clk, rst          : clock, asynchronous active-high reset
//   wr_valid_i        : a write was granted this cycle
//   wr_addr_i/_data_i : granted write address / data
//   rs1_addr_i/rs2_.. : ID-stage read addresses
//   rf_we_o/.._o      : registered RF write port
//   fwdK_hit_o/data_o : in-flight write matches rsK (data is zero on a miss)
module rv32i_rf_wr_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic            rf_we_o,
    output logic [AW-1:0]   rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            fwd1_hit_o,
    output logic [XLEN-1:0] fwd1_data_o,
    output logic            fwd2_hit_o,
    output logic [XLEN-1:0] fwd2_data_o
);

    logic            rf_we_q;
    logic            rf_we_d;
    logic [AW-1:0]   rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    // Writes to x0 are accepted upstream but never reach the register file.
    assign rf_we_d = wr_valid_i && (wr_addr_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            if (wr_valid_i) begin
                rf_waddr_q <= wr_addr_i;
                rf_wdata_q <= wr_data_i;
            end
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    // Forwarding of the value that lands in the RF at the end of this cycle.
    assign fwd1_hit_o  = rf_we_q && (rs1_addr_i == rf_waddr_q);
    assign fwd2_hit_o  = rf_we_q && (rs2_addr_i == rf_waddr_q);
    assign fwd1_data_o = fwd1_hit_o ? rf_wdata_q : '0;
    assign fwd2_data_o = fwd2_hit_o ? rf_wdata_q : '0;

endmodule

// File: rtl/rv32i_rf_wr_arbiter.sv
// Arbitrates the single register-file write port between WB (always wins),
// the ID-stage link write and the debug port, registers the winner for one
// cycle and forwards it to ID-stage reads.
//   clk, rst                      : clock, asynchronous active-high reset
//   wb_valid/addr/data            : WB write, never back-pressured
//   id_valid/ready/addr/data      : JAL/JALR link write
//   dbg_valid/ready/lock/addr/data: debug write; lock reserves the port
//   rf_we/rf_waddr/rf_wdata       : RF write port
//   rs1_addr/rs2_addr             : ID read addresses
//   fwd1_*/fwd2_*                 : forwarding of the in-flight write
//   locked                        : FSM is in LOCK
// Build option: define RF_ARB_RR_EN for round-robin ID/DBG arbitration in
// ARB; otherwise ID has fixed priority over DBG.
module rv32i_rf_wr_arbiter
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [AW-1:0]   id_addr,
    input  logic [XLEN-1:0] id_data,
    input  logic            dbg_valid,
    output logic            dbg_ready,
    input  logic            dbg_lock,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            fwd1_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd2_data,
    output logic            locked
);

    arb_state_e      state_q;
    logic [NREQ-1:0] gnt;
    logic            wr_valid;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

`ifdef RF_ARB_RR_EN
    logic [1:0] rr_ptr_q;   // requester favoured on the next ID/DBG tie
`endif

    // Grant: WB first, then LOCK restricts to DBG, else ID/DBG arbitration.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (wb_valid) begin
                gnt[REQ_WB] = 1'b1;
            end else if (state_q == LOCK) begin
                gnt[REQ_DBG] = dbg_valid;
            end else if (id_valid && dbg_valid) begin
`ifdef RF_ARB_RR_EN
                if (rr_ptr_q == 2'(REQ_DBG)) begin
                    gnt[REQ_DBG] = 1'b1;
                end else begin
                    gnt[REQ_ID] = 1'b1;
                end
`else
                gnt[REQ_ID] = 1'b1;
`endif
            end else begin
                gnt[REQ_ID]  = id_valid;
                gnt[REQ_DBG] = dbg_valid;
            end
        end
    end

    assign id_ready  = gnt[REQ_ID];
    assign dbg_ready = gnt[REQ_DBG];

    // Winning write payload.
    always_comb begin
        wr_valid = |gnt;
        wr_addr  = wb_addr;
        wr_data  = wb_data;
        if (gnt[REQ_ID]) begin
            wr_addr = id_addr;
            wr_data = id_data;
        end else if (gnt[REQ_DBG]) begin
            wr_addr = dbg_addr;
            wr_data = dbg_data;
        end
    end

    // Lock FSM; a WB-preempted debug beat leaves LOCK untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
        end else begin
            case (state_q)
                ARB: begin
                    if (gnt[REQ_DBG] && dbg_lock) begin
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if ((gnt[REQ_DBG] || !dbg_valid) && !dbg_lock) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign locked = (state_q == LOCK);

`ifdef RF_ARB_RR_EN
    // Round-robin pointer moves only on ID/DBG grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 2'(REQ_ID);
        end else if (gnt[REQ_ID]) begin
            rr_ptr_q <= 2'(REQ_DBG);
        end else if (gnt[REQ_DBG]) begin
            rr_ptr_q <= 2'(REQ_ID);
        end
    end
`endif

    rv32i_rf_wr_stage u_wr_stage (
        .clk         (clk),
        .rst         (rst),
        .wr_valid_i  (wr_valid),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rs1_addr_i  (rs1_addr),
        .rs2_addr_i  (rs2_addr),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .fwd1_hit_o  (fwd1_hit),
        .fwd1_data_o (fwd1_data),
        .fwd2_hit_o  (fwd2_hit),
        .fwd2_data_o (fwd2_data)
    );

endmodule

// File: tb/tb_rv32i_rf_wr_arbiter.sv
// Self-checking bench for rv32i_rf_wr_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_rv32i_rf_wr_arbiter;
    import rv32i_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            id_valid;
    logic            id_ready;
    logic [AW-1:0]   id_addr;
    logic [XLEN-1:0] id_data;
    logic            dbg_valid;
    logic            dbg_ready;
    logic            dbg_lock;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
    logic            locked;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_rf_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_addr(id_addr), .id_data(id_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .locked(locked)
    );

    task automatic clear_inputs();
        wb_valid = 0; wb_addr = '0; wb_data = '0;
        id_valid = 0; id_addr = '0; id_data = '0;
        dbg_valid = 0; dbg_lock = 0; dbg_addr = '0; dbg_data = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        id_valid = 1'b1; id_addr = 5'd4;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready got %b exp 0", id_ready); end
        checks++; if ({rf_we, rf_waddr, rf_wdata, locked} !== '0) begin errors++; $display("FAIL reset_outputs got we=%b a=%0d d=%h lk=%b exp all 0", rf_we, rf_waddr, rf_wdata, locked); end
        apply_reset();
        // Locked debug write to x3, then reset while it is in flight.
        dbg_valid = 1; dbg_lock = 1; dbg_addr = 5'd3; dbg_data = 32'h1234_5678;
        @(posedge clk); #1;
        dbg_valid = 0;
        checks++; if (rf_we !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL reset_pre_inflight got we=%b lk=%b exp 1 1", rf_we, locked); end
        #1 rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL reset_async got we=%b lk=%b exp 0 0", rf_we, locked); end
        clear_inputs();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({rf_we, rf_waddr, rf_wdata, locked, id_ready, dbg_ready, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data} !== '0) begin
            errors++; $display("FAIL reset_after got we=%b a=%0d d=%h lk=%b exp all 0", rf_we, rf_waddr, rf_wdata, locked);
        end
    endtask

    task automatic test_single_id();
        apply_reset();
        id_valid = 1; id_addr = 5'd5; id_data = 32'h0000_1004;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL single_id_ready got %b exp 1", id_ready); end
        @(posedge clk); #1;
        id_valid = 0; rs1_addr = 5'd5; rs2_addr = 5'd6;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h0000_1004) begin
            errors++; $display("FAIL single_id_write got we=%b a=%0d d=%h exp 1 5 00001004", rf_we, rf_waddr, rf_wdata);
        end
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h0000_1004) begin errors++; $display("FAIL single_id_fwd1 got %b %h exp 1 00001004", fwd1_hit, fwd1_data); end
        checks++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin errors++; $display("FAIL single_id_fwd2 got %b %h exp 0 0", fwd2_hit, fwd2_data); end
    endtask

    task automatic test_wb_collision();
        apply_reset();
        wb_valid = 1; wb_addr = 5'd7; wb_data = 32'hAAAA_0001;
        id_valid = 1; id_addr = 5'd7; id_data = 32'h0000_2008;
        @(negedge clk);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL coll_id_stall got %b exp 0", id_ready); end
        @(posedge clk); #1;
        wb_valid = 0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAAAA_0001) begin
            errors++; $display("FAIL coll_wb_write got we=%b a=%0d d=%h exp 1 7 aaaa0001", rf_we, rf_waddr, rf_wdata);
        end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL coll_id_ready got %b exp 1", id_ready); end
        @(posedge clk); #1;
        id_valid = 0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_2008) begin
            errors++; $display("FAIL coll_id_write got we=%b a=%0d d=%h exp 1 7 00002008", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_x0_dbg();
        apply_reset();
        dbg_valid = 1; dbg_addr = 5'd0; dbg_data = 32'hDEAD_BEEF; rs1_addr = 5'd0;
        @(negedge clk);
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL x0_dbg_ready got %b exp 1", dbg_ready); end
        @(posedge clk); #1;
        dbg_valid = 0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_rf_we got %b exp 0", rf_we); end
        checks++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0) begin errors++; $display("FAIL x0_fwd1 got %b %h exp 0 0", fwd1_hit, fwd1_data); end
    endtask

    task automatic test_dbg_lock();
        apply_reset();
        dbg_valid = 1; dbg_lock = 1; dbg_addr = 5'd10; dbg_data = 32'h0000_0A01;
        @(negedge clk);
        checks++; if (dbg_ready !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL lock_beat1 got rdy=%b lk=%b exp 1 0", dbg_ready, locked); end
        for (int b = 2; b <= 3; b++) begin
            @(posedge clk); #1;
            id_valid = 1; id_addr = 5'd11; id_data = 32'h0000_0B00;
            dbg_lock = (b == 2); dbg_data = 32'h0000_0A00 + 32'(b);
            @(negedge clk);
            checks++; if (locked !== 1'b1 || id_ready !== 1'b0 || dbg_ready !== 1'b1) begin
                errors++; $display("FAIL lock_beat%0d got lk=%b id=%b dbg=%b exp 1 0 1", b, locked, id_ready, dbg_ready);
            end
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h0000_0A00 + 32'(b - 1)) begin
                errors++; $display("FAIL lock_write%0d got we=%b a=%0d d=%h exp 1 10 %h", b, rf_we, rf_waddr, rf_wdata, 32'h0000_0A00 + 32'(b - 1));
            end
        end
        @(posedge clk); #1;
        dbg_valid = 0; dbg_lock = 0;
        @(negedge clk);
        checks++; if (locked !== 1'b0 || id_ready !== 1'b1) begin errors++; $display("FAIL lock_exit got lk=%b id=%b exp 0 1", locked, id_ready); end
        @(posedge clk); #1;
        id_valid = 0;
    endtask

    task automatic test_id_dbg_contention();
        logic exp_id;
        apply_reset();
        id_valid = 1; dbg_valid = 1; dbg_lock = 0;
        for (int c = 0; c < 4; c++) begin
            id_addr = 5'd12; id_data = 32'h100 + 32'(c);
            dbg_addr = 5'd13; dbg_data = 32'h200 + 32'(c);
`ifdef RF_ARB_RR_EN
            exp_id = (c % 2 == 0);
`else
            exp_id = 1'b1;
`endif
            @(negedge clk);
            checks++; if (id_ready !== exp_id || dbg_ready !== !exp_id) begin
                errors++; $display("FAIL contend_c%0d got id=%b dbg=%b exp %b %b", c, id_ready, dbg_ready, exp_id, !exp_id);
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic            m_lock, m_rr_dbg, m_we;
        logic [AW-1:0]   m_addr;
        logic [XLEN-1:0] m_data;
        logic            e_id, e_dbg, e_any, e_h1, e_h2;
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic [XLEN-1:0] gold_rf [NREG];
        logic [XLEN-1:0] seen_rf [NREG];
        for (int r = 0; r < int'(NREG); r++) begin gold_rf[r] = '0; seen_rf[r] = '0; end
        apply_reset();
        m_lock = 0; m_rr_dbg = 0; m_we = 0; m_addr = '0; m_data = '0;
        for (int i = 0; i < 600; i++) begin
            wb_valid = ($urandom_range(0, 3) == 0);
            wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
            if (!id_valid && $urandom_range(0, 1) == 1) begin
                id_valid = 1; id_addr = AW'($urandom_range(0, 7)); id_data = $urandom;
            end
            if (!dbg_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    dbg_valid = 1; dbg_addr = AW'($urandom_range(0, 7)); dbg_data = $urandom;
                    dbg_lock = 1'($urandom_range(0, 1));
                end else begin
                    dbg_lock = ($urandom_range(0, 4) == 0);
                end
            end
            rs1_addr = ($urandom_range(0, 1) == 1) ? m_addr : AW'($urandom_range(0, 7));
            rs2_addr = AW'($urandom_range(0, 7));
            // Expected grants from the sharing rules.
            e_id = 0; e_dbg = 0;
            if (!wb_valid) begin
                if (m_lock) e_dbg = dbg_valid;
                else if (id_valid && dbg_valid) begin
`ifdef RF_ARB_RR_EN
                    e_dbg = m_rr_dbg; e_id = !m_rr_dbg;
`else
                    e_id = 1;
`endif
                end else begin e_id = id_valid; e_dbg = dbg_valid; end
            end
            @(negedge clk);
            if (rf_we === 1'b1) seen_rf[rf_waddr] = rf_wdata;
            checks++; if (id_ready !== e_id || dbg_ready !== e_dbg) begin
                errors++; $display("FAIL rand_ready c%0d got id=%b dbg=%b exp %b %b", i, id_ready, dbg_ready, e_id, e_dbg);
            end
            checks++; if (locked !== m_lock) begin errors++; $display("FAIL rand_locked c%0d got %b exp %b", i, locked, m_lock); end
            checks++; if (rf_we !== m_we || (m_we && (rf_waddr !== m_addr || rf_wdata !== m_data))) begin
                errors++; $display("FAIL rand_write c%0d got we=%b a=%0d d=%h exp we=%b a=%0d d=%h", i, rf_we, rf_waddr, rf_wdata, m_we, m_addr, m_data);
            end
            e_h1 = m_we && (rs1_addr == m_addr);
            e_h2 = m_we && (rs2_addr == m_addr);
            checks++; if (fwd1_hit !== e_h1 || fwd1_data !== (e_h1 ? m_data : '0) || fwd2_hit !== e_h2 || fwd2_data !== (e_h2 ? m_data : '0)) begin
                errors++; $display("FAIL rand_fwd c%0d got %b %h %b %h exp %b %b", i, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, e_h1, e_h2);
            end
            // Advance the model by one clock.
            e_any = wb_valid || e_id || e_dbg;
            w_addr = wb_valid ? wb_addr : (e_id ? id_addr : dbg_addr);
            w_data = wb_valid ? wb_data : (e_id ? id_data : dbg_data);
            m_we = e_any && (w_addr != 0);
            if (e_any) begin m_addr = w_addr; m_data = w_data; end
            if (m_we) gold_rf[w_addr] = w_data;
            if (!m_lock && e_dbg && dbg_lock) m_lock = 1;
            else if (m_lock && (e_dbg || !dbg_valid) && !dbg_lock) m_lock = 0;
            if (e_id) m_rr_dbg = 1;
            else if (e_dbg) m_rr_dbg = 0;
            @(posedge clk); #1;
            if (e_id) id_valid = 0;
            if (e_dbg) dbg_valid = 0;
        end
        clear_inputs();
        @(negedge clk);
        if (rf_we === 1'b1) seen_rf[rf_waddr] = rf_wdata;
        for (int r = 0; r < int'(NREG); r++) begin
            checks++; if (seen_rf[r] !== gold_rf[r]) begin errors++; $display("FAIL rand_rf x%0d got %h exp %h", r, seen_rf[r], gold_rf[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_id();
        test_wb_collision();
        test_x0_dbg();
        test_dbg_lock();
        test_id_dbg_contention();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
